// File: rtl/axis_y_requant.sv
// Requantizes R-word signed accumulator beats to WO-bit words (round half up, saturate)
// and serializes each held beat into R/P output beats of P words each.
module axis_y_requant #(
    parameter int R       = 2,
    parameter int P       = 1,
    parameter int WY      = 17,
    parameter int WO      = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [R*WY-1:0]      s_data,
    input  logic [R-1:0]         s_keep,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [P*WO-1:0]      m_data,
    output logic [P-1:0]         m_keep,
    output logic                 m_last
);

    localparam int G  = R / P;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0] LAST_G = GW'(G - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam int SAT_MAX_I = (1 << (WO - 1)) - 1;
    localparam logic signed [WY:0] SAT_MAX = (WY + 1)'(SAT_MAX_I);
    localparam logic signed [WY:0] SAT_MIN = (WY + 1)'(-SAT_MAX_I - 1);

    // One extra bit of headroom so the rounding addend can never overflow.
    function automatic logic [WO-1:0] requant_word(input logic [WY-1:0] y,
                                                   input logic [SHIFT_W-1:0] sh);
        logic signed [WY:0] ext;
        logic signed [WY:0] rnd;
        logic signed [WY:0] q;
        ext = $signed({y[WY-1], y});
        rnd = '0;
        if (sh == '0) begin
            q = ext;
        end else begin
            rnd = $signed({{WY{1'b0}}, 1'b1} << (sh - 1'b1));
            q   = (ext + rnd) >>> sh;
        end
        if (q > SAT_MAX) begin
            q = SAT_MAX;
        end else if (q < SAT_MIN) begin
            q = SAT_MIN;
        end
        return q[WO-1:0];
    endfunction

    logic [0:0]      state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [R*WO-1:0] data_q, data_d;
    logic [R-1:0]    keep_q, keep_d;
    logic            last_q, last_d;

    logic [R*WO-1:0] data_req;
    logic            full;
    logic            last_grp;
    logic            s_hs;
    logic            m_hs;

    assign full     = (state_q == ST_FULL);
    assign last_grp = (g_q == LAST_G);
    assign m_hs     = full & m_ready;
    // Combinational from m_ready so a finishing beat and the next one share a cycle.
    assign s_ready  = !rst & (!full | (m_hs & last_grp));
    assign s_hs     = s_valid & s_ready;

    assign m_valid = full;
    assign m_data  = data_q[int'(g_q) * P * WO +: P * WO];
    assign m_keep  = keep_q[int'(g_q) * P +: P];
    assign m_last  = full & last_q & last_grp;

    always_comb begin
        data_req = '0;
        for (int i = 0; i < R; i++) begin
            data_req[i * WO +: WO] = requant_word(s_data[i * WY +: WY], shift);
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d = state_q;
        g_d     = g_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (m_hs) begin
            if (!last_grp) begin
                g_d = GW'(g_q + 1'b1);
            end else begin
                state_d = ST_EMPTY;
                g_d     = '0;
            end
        end
        if (s_hs) begin
            state_d = ST_FULL;
            g_d     = '0;
            data_d  = data_req;
            keep_d  = s_keep;
            last_d  = s_last;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            g_q     <= '0;
            // NOTE: the payload is reset too because m_data/m_keep must read zero out of reset.
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_axis_y_requant.sv
// Directed and random-stream checks of axis_y_requant with R=2/P=1 and R=4/P=2 instances.
module tb_axis_y_requant;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [4:0]  shift = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [33:0] s_data = '0;
    logic [1:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic [0:0]  m_keep;
    logic        m_last;

    logic [4:0]  shift4 = '0;
    logic        s_valid4 = 1'b0;
    logic        s_ready4;
    logic [67:0] s_data4 = '0;
    logic [3:0]  s_keep4 = '0;
    logic        s_last4 = 1'b0;
    logic        m_valid4;
    logic        m_ready4 = 1'b0;
    logic [15:0] m_data4;
    logic [1:0]  m_keep4;
    logic        m_last4;

    always #5 clk = ~clk;

    axis_y_requant #(.R(2), .P(1), .WY(17), .WO(8), .SHIFT_W(5)) u_dut (
        .clk(clk), .rst(rst), .shift(shift),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
    );

    axis_y_requant #(.R(4), .P(2), .WY(17), .WO(8), .SHIFT_W(5)) u_dut4 (
        .clk(clk), .rst(rst), .shift(shift4),
        .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .s_keep(s_keep4), .s_last(s_last4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4), .m_keep(m_keep4), .m_last(m_last4)
    );

    // Reference requantizer built on integer floor division.
    function automatic logic [7:0] ref_requant(input int y, input int sh);
        int d, num, q;
        if (sh == 0) begin
            q = y;
        end else begin
            d   = 1 << sh;
            num = y + d / 2;
            if (num >= 0) q = num / d;
            else          q = -((-num + d - 1) / d);
        end
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat2(input int w0, input int w1, input logic [1:0] keep,
                              input logic last, input int sh);
        int n;
        s_data  = {17'(w1), 17'(w0)};
        s_keep  = keep;
        s_last  = last;
        shift   = 5'(sh);
        s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_handshake: s_ready=%b after %0d cycles, want 1", s_ready, n);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic take_beat(output logic v, output logic [7:0] d, output logic l);
        @(negedge clk);
        v = m_valid;
        d = m_data;
        l = m_last;
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
    endtask

    task automatic load_stream_beat(input int beat, input int len);
        for (int i = 0; i < 2; i++) begin
            s_data[i * 17 +: 17] = 17'($urandom_range(0, 131071));
        end
        s_keep  = 2'($urandom_range(0, 3));
        shift   = 5'($urandom_range(0, 16));
        s_last  = (beat == len - 1);
        s_valid = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_last, m_keep, m_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset_r2: rdy=%b v=%b l=%b k=%b d=%h, want all zero",
                     s_ready, m_valid, m_last, m_keep, m_data);
        end
        checks++;
        if ({s_ready4, m_valid4, m_last4, m_keep4, m_data4} !== 21'h0) begin
            errors++;
            $display("FAIL reset_r4: rdy=%b v=%b l=%b k=%b d=%h, want all zero",
                     s_ready4, m_valid4, m_last4, m_keep4, m_data4);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: s_ready=%b, want 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic v, l;
        logic [7:0] d;
        send_beat2(100, -100, 2'b11, 1'b1, 4);
        take_beat(v, d, l);
        checks++;
        if ({v, d, l} !== {1'b1, 8'd6, 1'b0}) begin
            errors++;
            $display("FAIL basic_w0: v=%b d=%0d l=%b, want v=1 d=6 l=0", v, $signed(d), l);
        end
        take_beat(v, d, l);
        checks++;
        if ({v, d, l} !== {1'b1, 8'hFA, 1'b1}) begin
            errors++;
            $display("FAIL basic_w1: v=%b d=%0d l=%b, want v=1 d=-6 l=1", v, $signed(d), l);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drained: m_valid=%b, want 0", m_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_saturate();
        // w0, w1, shift, expected out0, expected out1
        int vec [4][5] = '{
            '{300, -300, 0, 127, -128},
            '{5, -5, 0, 5, -5},
            '{3, -3, 1, 2, -1},
            '{65535, -65536, 16, 1, -1}
        };
        logic v, l;
        logic [7:0] d;
        logic [7:0] want;
        for (int t = 0; t < 4; t++) begin
            send_beat2(vec[t][0], vec[t][1], 2'b11, 1'b0, vec[t][2]);
            for (int w = 0; w < 2; w++) begin
                take_beat(v, d, l);
                want = 8'(vec[t][3 + w]);
                checks++;
                if ({v, d, l} !== {1'b1, want, 1'b0}) begin
                    errors++;
                    $display("FAIL round_sat_v%0d_w%0d: v=%b d=%0d l=%b, want v=1 d=%0d l=0",
                             t, w, v, $signed(d), l, $signed(want));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        send_beat2(50, -50, 2'b11, 1'b1, 2);
        s_data  = {17'd1, 17'd1};
        s_keep  = 2'b11;
        s_last  = 1'b1;
        shift   = 5'd0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({m_valid, m_data, m_last, s_ready} !== {1'b1, 8'd13, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d: v=%b d=%0d l=%b rdy=%b, want v=1 d=13 l=0 rdy=0",
                         i, m_valid, $signed(m_data), m_last, s_ready);
            end
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last, s_ready} !== {1'b1, 8'd13, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_w0: v=%b d=%0d l=%b rdy=%b, want v=1 d=13 l=0 rdy=0",
                     m_valid, $signed(m_data), m_last, s_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last, s_ready} !== {1'b1, 8'hF4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL bp_w1: v=%b d=%0d l=%b rdy=%b, want v=1 d=-12 l=1 rdy=1",
                     m_valid, $signed(m_data), m_last, s_ready);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last} !== {1'b1, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_w0: v=%b d=%0d l=%b, want v=1 d=1 l=0",
                     m_valid, $signed(m_data), m_last);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last} !== {1'b1, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_w1: v=%b d=%0d l=%b, want v=1 d=1 l=1",
                     m_valid, $signed(m_data), m_last);
        end
        @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: m_valid=%b, want 0", m_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        exp_t q[$];
        exp_t e;
        int pkt = 0, beat = 0, len, cyc;
        bit done = 0, started = 0, hs;
        logic prev_sr = 1'b0;
        m_ready = 1'b1;
        len = $urandom_range(1, 4);
        load_stream_beat(beat, len);
        for (cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (started && !done) begin
                checks++;
                if (m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_gap: cycle %0d m_valid=%b, want 1", cyc, m_valid);
                end
                checks++;
                if (s_ready === prev_sr) begin
                    errors++;
                    $display("FAIL stream_ready_cadence: cycle %0d s_ready=%b, want %b",
                             cyc, s_ready, !prev_sr);
                end
            end
            if (m_valid) begin
                started = 1;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: unexpected output d=%h", m_data);
                end else begin
                    e = q.pop_front();
                    if ({m_data, m_keep, m_last} !== {e.d, e.k, e.l}) begin
                        errors++;
                        $display("FAIL stream_word: cycle %0d d=%0d k=%b l=%b, want d=%0d k=%b l=%b",
                                 cyc, $signed(m_data), m_keep, m_last, $signed(e.d), e.k, e.l);
                    end
                end
            end
            prev_sr = s_ready;
            hs = s_valid && s_ready;
            if (hs) begin
                for (int i = 0; i < 2; i++) begin
                    e.d = ref_requant(int'($signed(s_data[i * 17 +: 17])), int'(shift));
                    e.k = s_keep[i];
                    e.l = s_last && (i == 1);
                    q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            if (hs) begin
                if (s_last) begin
                    pkt++;
                    beat = 0;
                    len = $urandom_range(1, 4);
                end else begin
                    beat++;
                end
                if (pkt == 50) begin
                    s_valid = 1'b0;
                    done = 1;
                end else begin
                    load_stream_beat(beat, len);
                end
            end
            if (done && q.size() == 0) break;
        end
        checks++;
        if (!(done && q.size() == 0)) begin
            errors++;
            $display("FAIL stream_timeout: packets=%0d pending=%0d, want 50 and 0", pkt, q.size());
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wide_keep();
        s_data4  = {17'd4, 17'd3, 17'd2, 17'd1};
        s_keep4  = 4'b0111;
        s_last4  = 1'b1;
        shift4   = 5'd0;
        s_valid4 = 1'b1;
        m_ready4 = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL wide_ready: s_ready=%b, want 1", s_ready4);
        end
        @(posedge clk);
        #1 s_valid4 = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid4, m_data4, m_keep4, m_last4} !== {1'b1, 16'h0201, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL wide_g0: v=%b d=%h k=%b l=%b, want v=1 d=0201 k=11 l=0",
                     m_valid4, m_data4, m_keep4, m_last4);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({m_valid4, m_data4, m_keep4, m_last4} !== {1'b1, 16'h0403, 2'b01, 1'b1}) begin
            errors++;
            $display("FAIL wide_g1: v=%b d=%h k=%b l=%b, want v=1 d=0403 k=01 l=1",
                     m_valid4, m_data4, m_keep4, m_last4);
        end
        @(posedge clk);
        #1 m_ready4 = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL wide_drained: m_valid=%b, want 0", m_valid4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic v, l;
        logic [7:0] d;
        send_beat2(10, 20, 2'b11, 1'b1, 0);
        take_beat(v, d, l);
        checks++;
        if ({v, d, l} !== {1'b1, 8'd10, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_g0: v=%b d=%0d l=%b, want v=1 d=10 l=0", v, $signed(d), l);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready: s_ready=%b during reset, want 0", s_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_flushed_%0d: m_valid=%b, want 0", i, m_valid);
            end
        end
        @(posedge clk);
        #1;
        send_beat2(7, -7, 2'b11, 1'b1, 0);
        take_beat(v, d, l);
        checks++;
        if ({v, d, l} !== {1'b1, 8'd7, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_next_w0: v=%b d=%0d l=%b, want v=1 d=7 l=0", v, $signed(d), l);
        end
        take_beat(v, d, l);
        checks++;
        if ({v, d, l} !== {1'b1, 8'hF9, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_next_w1: v=%b d=%0d l=%b, want v=1 d=-7 l=1", v, $signed(d), l);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_round_saturate();
        test_backpressure();
        test_wide_keep();
        test_streaming();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
